// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end.
// Issues requests to instruction memory within a credit budget, tracks the PC of
// every granted request, buffers responses in a small FIFO and presents one
// instruction per cycle to decode. Redirects flush the buffer and discard the
// responses still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        inst_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  // PCs of granted requests, consumed in order as responses come back
  logic [31:0]   pend_pc_q [FIFO_DEPTH];
  logic [31:0]   pend_pc_d [FIFO_DEPTH];
  logic [PW-1:0] pend_wr_q, pend_wr_d;
  logic [PW-1:0] pend_rd_q, pend_rd_d;

  // response buffer holding {PC, instruction} pairs
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic [PW-1:0] fifo_wr_q, fifo_wr_d;
  logic [PW-1:0] fifo_rd_q, fifo_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_q, pc_d;
  logic          valid_q, valid_d;

  logic          credit_ok_s;
  logic          grant_s;
  logic          resp_s;
  logic          push_s;
  logic          pop_s;

  // Every in-flight request owns a buffer slot, so the buffer can never overflow.
  assign credit_ok_s = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
  assign imem_req    = (state_q == FETCH) & ~redirect & credit_ok_s;
  assign imem_addr   = fetch_pc_q;
  assign grant_s     = imem_req & imem_gnt;
  // A response with nothing outstanding belongs to no live request.
  assign resp_s      = imem_rvalid & (outst_q != C_ZERO);
  assign push_s      = resp_s & ~redirect & (drop_q == C_ZERO);
  assign pop_s       = ~redirect & ~stall & (fifo_cnt_q != C_ZERO);

  assign instruction = instr_q;
  assign PC          = pc_q;
  assign inst_valid  = valid_q;

  // Next state and number of in-flight responses still to be thrown away.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH, DRAIN: begin
        if (redirect) begin
          drop_d  = outst_q - CW'(resp_s);
          state_d = (drop_d != C_ZERO) ? DRAIN : FETCH;
        end else if (state_q == DRAIN) begin
          drop_d  = drop_q - CW'(resp_s);
          state_d = (drop_d == C_ZERO) ? FETCH : DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch address, in-flight count and per-request PC tracking.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + CW'(grant_s) - CW'(resp_s);
    pend_pc_d  = pend_pc_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (grant_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    if (grant_s) begin
      pend_pc_d[pend_wr_q] = fetch_pc_q;
      pend_wr_d            = pend_wr_q + P_ONE;
    end else begin
      pend_wr_d = pend_wr_q;
    end
    if (resp_s) begin
      pend_rd_d = pend_rd_q + P_ONE;
    end else begin
      pend_rd_d = pend_rd_q;
    end
  end

  // Response buffer: pop reads the old head, so a push is visible a cycle later.
  always_comb begin
    fifo_pc_d   = fifo_pc_q;
    fifo_data_d = fifo_data_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (redirect) begin
      fifo_wr_d  = {PW{1'b0}};
      fifo_rd_d  = {PW{1'b0}};
      fifo_cnt_d = C_ZERO;
    end else begin
      if (push_s) begin
        fifo_pc_d[fifo_wr_q]   = pend_pc_q[pend_rd_q];
        fifo_data_d[fifo_wr_q] = imem_rdata;
        fifo_wr_d              = fifo_wr_q + P_ONE;
      end else begin
        fifo_wr_d = fifo_wr_q;
      end
      if (pop_s) begin
        fifo_rd_d = fifo_rd_q + P_ONE;
      end else begin
        fifo_rd_d = fifo_rd_q;
      end
      fifo_cnt_d = fifo_cnt_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Decode-facing outputs: redirect wins, stall freezes, otherwise pop or NOP.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (redirect) begin
      instr_d = NOP_INSN;
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (fifo_cnt_q != C_ZERO) begin
        instr_d = fifo_data_q[fifo_rd_q];
        pc_d    = fifo_pc_q[fifo_rd_q];
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSN;
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      outst_q    <= C_ZERO;
      drop_q     <= C_ZERO;
      pend_wr_q  <= {PW{1'b0}};
      pend_rd_q  <= {PW{1'b0}};
      fifo_wr_q  <= {PW{1'b0}};
      fifo_rd_q  <= {PW{1'b0}};
      fifo_cnt_q <= C_ZERO;
      instr_q    <= NOP_INSN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // Storage arrays; their contents are only meaningful under the pointers above.
  always_ff @(posedge clk) begin
    pend_pc_q   <= pend_pc_d;
    fifo_pc_q   <= fifo_pc_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a queue-based reference
// model and an in-order memory model with random grant and latency.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RPC      = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int          NPHASE   = 4;
  localparam int          NCYC     = 400;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        inst_valid;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .PC          (PC),
    .inst_valid  (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: 0 = idle, 1 = fetching, 2 = draining
  int          m_state;
  logic [31:0] m_fpc;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_drop;
  logic [31:0] m_pend[$];   // PCs of granted, unanswered requests
  logic [63:0] m_fifo[$];   // {pc, instruction} waiting for decode

  // memory model: addresses granted, with earliest response cycle
  logic [31:0] mq_addr[$];
  int          mq_ready[$];

  int          cyc = 0;
  int          rst_hold = 2;
  int          rel_cyc = 0;
  bit          seen_first = 1'b0;
  logic [31:0] xmask;

  task automatic model_reset();
    m_state = 0;
    m_fpc   = RPC;
    m_instr = NOP_INSN;
    m_pc    = RPC;
    m_valid = 1'b0;
    m_drop  = 0;
    m_pend.delete();
    m_fifo.delete();
    mq_addr.delete();
    mq_ready.delete();
  endtask

  function automatic bit model_req();
    return (m_state == 1) && !redirect && ((m_pend.size() + m_fifo.size()) < DEPTH);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step(input int ph);
    bit          grant;
    bit          resp;
    bit          keep;
    logic [31:0] rp;
    grant = model_req() && imem_gnt;
    resp  = imem_rvalid && (m_pend.size() > 0);
    keep  = 1'b0;
    rp    = 32'h0;
    if (resp) begin
      rp   = m_pend.pop_front();
      keep = !redirect && (m_drop == 0);
      void'(mq_addr.pop_front());
      void'(mq_ready.pop_front());
    end
    if (grant) begin
      m_pend.push_back(m_fpc);
      mq_addr.push_back(m_fpc);
      mq_ready.push_back(cyc + 1 + ((ph == 0) ? 0 : int'($urandom_range(2))));
      m_fpc = m_fpc + 32'd4;
    end
    if (redirect) begin
      m_fpc   = redirect_pc;
      m_fifo.delete();
      m_instr = NOP_INSN;
      m_valid = 1'b0;
      m_pc    = redirect_pc;
      m_drop  = m_pend.size();
      m_state = (m_drop > 0) ? 2 : 1;
    end else begin
      if (!stall) begin
        if (m_fifo.size() > 0) begin
          {m_pc, m_instr} = m_fifo.pop_front();
          m_valid = 1'b1;
        end else begin
          m_instr = NOP_INSN;
          m_valid = 1'b0;
        end
      end
      if (keep) m_fifo.push_back({rp, imem_rdata});
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 2) begin
        if (resp) m_drop--;
        if (m_drop == 0) m_state = 1;
      end
    end
  endtask

  // Randomize inputs for this cycle according to the phase.
  task automatic drive_inputs(input int ph, input int c);
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) begin
        rst     = 1'b0;
        rel_cyc = cyc;
      end
    end else if (ph == 3 && $urandom_range(99) < 2) begin
      rst      = 1'b1;
      rst_hold = 1 + int'($urandom_range(1));
      model_reset();
    end
    case (ph)
      0:       stall = 1'b0;
      1:       stall = ((c % 16) >= 8) && ((c % 16) < 13);
      default: stall = ($urandom_range(99) < 20);
    endcase
    redirect    = (ph >= 2) && ($urandom_range(99) < 6);
    redirect_pc = $urandom() & 32'h0000_FFFC;
    imem_gnt    = (ph <= 1) ? 1'b1 : ($urandom_range(99) < 55);
    xmask       = (ph == 0) ? 32'h0 : 32'h5A5A_0000;
    if (mq_addr.size() > 0 && mq_ready[0] <= cyc && (ph == 0 || $urandom_range(99) < 70)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq_addr[0] ^ xmask;
    end else if (mq_addr.size() == 0 && ph >= 2 && $urandom_range(99) < 20) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom();
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    for (int ph = 0; ph < NPHASE; ph++) begin
      for (int c = 0; c < NCYC; c++) begin
        drive_inputs(ph, c);
        #3;
        check_eq("imem_req", imem_req, model_req());
        check_eq("imem_addr", imem_addr, m_fpc);
        check_eq("instruction", instruction, m_instr);
        check_eq("pc", PC, m_pc);
        check_eq("inst_valid", inst_valid, m_valid);
        if (ph == 0 && !seen_first && inst_valid === 1'b1) begin
          seen_first = 1'b1;
          check_eq("first_valid_latency", cyc - rel_cyc, 32'd4);
        end
        if (!rst) model_step(ph);
        @(posedge clk);
        #1;
        cyc++;
      end
      if (ph == 0) check_eq("first_valid_seen", seen_first, 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, response-buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  decode stage not accepting; hold outputs.
REQ-006 redirect  input  1  control-flow change (branch/jump/flush).
REQ-007 redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  request address.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 instruction  output  32  instruction to decode.
REQ-014 PC  output  32  address of instruction.
REQ-015 inst_valid  output  1  instruction/PC hold a real fetched instruction.

Function
REQ-016 FSM states: IDLE, FETCH, DRAIN.
REQ-017 IDLE -> FETCH on the first clock edge with rst low.
REQ-018 fetch_pc register drives imem_addr at all times; +4 on every grant (imem_req & imem_gnt).
REQ-019 imem_req = (state==FETCH) & !redirect & (outstanding + fifo_count < FIFO_DEPTH).
REQ-020 imem_gnt=0 with imem_req=1: imem_addr and imem_req stay stable.
REQ-021 outstanding counter: +1 on grant, -1 on accepted response, unchanged when both occur together; never exceeds FIFO_DEPTH.
REQ-022 imem_rvalid while outstanding==0 is ignored; no state change.
REQ-023 Accepted response with drop_cnt==0 pushes {PC, rdata} into the FIFO; PC is tracked per grant in order.
REQ-024 No FIFO bypass: response in cycle R reaches the outputs in cycle R+2 at the earliest.
REQ-025 Output update when stall=0: if FIFO non-empty, pop head into instruction/PC with inst_valid=1; else instruction=32'h0000_0013 (NOP), inst_valid=0, PC holds.
REQ-026 stall=1 without redirect: instruction, PC, inst_valid and FIFO contents hold; FIFO pushes and requests continue within credit.
REQ-027 Credit rule guarantees no push into a full FIFO; simultaneous push and pop are allowed.
REQ-028 Sustained throughput of one instruction per cycle with 1-cycle memory latency, no stalls, no redirects.
REQ-029 Redirect has priority over stall. On redirect: fetch_pc <= redirect_pc; FIFO cleared; instruction <= NOP; inst_valid <= 0; PC <= redirect_pc.
REQ-030 Also on redirect: drop_cnt <= outstanding after this cycle's response; a response arriving in the redirect cycle is discarded.
REQ-031 After redirect: next state DRAIN if drop_cnt>0, else FETCH.
REQ-032 DRAIN: no requests; each response decrements drop_cnt and is discarded; -> FETCH when drop_cnt reaches 0.
REQ-033 Redirect during DRAIN reloads fetch_pc and keeps draining.

Reset
REQ-034 rst=1 immediately forces: state IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instruction=32'h0000_0013, PC=RESET_PC, inst_valid=0, outstanding=0, drop_cnt=0, FIFO empty.
REQ-035 Responses arriving after reset for pre-reset requests are ignored per REQ-022.

Verification
REQ-036 Reset release; memory always grants, 1-cycle latency, rdata=addr -> PC/instruction 0x0,0x4,0x8... with inst_valid first high 4 cycles after release, then every cycle, no gaps or duplicates.
REQ-037 Steady stream, stall held 5 cycles -> outputs frozen; imem_req low once outstanding+fifo_count=4; after release, sequence continues with no loss or duplication.
REQ-038 Two requests outstanding (0x8, 0xC), redirect to 0x100 -> both responses discarded, imem_req low until drained, next valid output PC=0x100.
REQ-039 imem_gnt low 3 cycles at addr 0x10 -> imem_addr stays 0x10, no increment, output order preserved.
REQ-040 redirect=1 and stall=1 in the same cycle, redirect_pc=0x200 -> next cycle instruction=NOP, inst_valid=0, PC=0x200.
REQ-041 rst asserted mid-stream with 2 outstanding -> outputs take REQ-034 values in the same cycle; late imem_rvalid pulses ignored; fetch restarts at RESET_PC.
